trap_ctrl: RTL and testbench

Trap sequencer between the pipeline and the CSR file. It samples synchronous exceptions, `mret` and the external and timer interrupt lines, and picks one winner by fixed priority. It then drives the CSR file's `excepttype`/`current_inst_addr` inputs for exactly one cycle, and afterwards issues a pipeline flush with the redirect PC taken from `mtvec` or `mepc`. It is the only agent allowed to drive the CSR file's exception inputs.

---
 rtl/trap_ctrl_pkg.sv | 70 +++++++
 rtl/trap_prio_enc.sv | 67 ++++++
 rtl/trap_ctrl.sv | 147 ++++++++++++++
 tb/tb_trap_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared trap definitions: excepttype codes, CSR bit indices, cause numbers,
// the latched event payload and the redirect-target helper.
package trap_ctrl_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned EXC_W   = 6;
  localparam int unsigned CAUSE_W = 5;

  // excepttype codes presented to the CSR file
  localparam logic [XLEN-1:0] EXC_INT_EXT        = 32'h0000_0000;
  localparam logic [XLEN-1:0] EXC_ECALL          = 32'h0000_0001;
  localparam logic [XLEN-1:0] EXC_TRAP           = 32'h0000_0002;
  localparam logic [XLEN-1:0] EXC_INT_TIMER      = 32'h0000_0003;
  localparam logic [XLEN-1:0] EXC_OVERFLOW       = 32'h0000_0004;
  localparam logic [XLEN-1:0] EXC_INST_INVALID   = 32'h0000_0005;
  localparam logic [XLEN-1:0] EXC_LOAD_MISALIGN  = 32'h0000_0006;
  localparam logic [XLEN-1:0] EXC_STORE_MISALIGN = 32'h0000_0007;
  localparam logic [XLEN-1:0] EXC_MRET           = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] EXC_NONE           = 32'h0000_00FF;

  // bit positions inside exc_code_i
  localparam int unsigned EXC_BIT_INST_INVALID   = 0;
  localparam int unsigned EXC_BIT_ECALL          = 1;
  localparam int unsigned EXC_BIT_TRAP           = 2;
  localparam int unsigned EXC_BIT_LOAD_MISALIGN  = 3;
  localparam int unsigned EXC_BIT_STORE_MISALIGN = 4;
  localparam int unsigned EXC_BIT_OVERFLOW       = 5;

  localparam int unsigned CSR_MSTATUS_MIE = 3;
  localparam int unsigned CSR_MIE_MTIE    = 7;
  localparam int unsigned CSR_MIE_MEIE    = 11;

  localparam logic [CAUSE_W-1:0] CAUSE_EXT   = 5'd11;
  localparam logic [CAUSE_W-1:0] CAUSE_TIMER = 5'd7;

  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COMMIT   = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0]    code;
    logic [CAUSE_W-1:0] cause;
    logic               is_int;
    logic               is_mret;
  } trap_evt_t;

  // Redirect PC: mepc for mret, mtvec base otherwise, plus cause*4 for vectored interrupts.
  function automatic logic [XLEN-1:0] trap_target(
    input trap_evt_t       evt,
    input logic            vec_en,
    input logic [XLEN-1:0] mtvec,
    input logic [XLEN-1:0] mepc
  );
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] target;
    base   = {mtvec[XLEN-1:2], 2'b00};
    target = base;
    if (evt.is_mret) begin
      target = mepc;
    end else if (evt.is_int && vec_en && (mtvec[1:0] == MTVEC_MODE_VECTORED)) begin
      target = base + (XLEN'(evt.cause) << 2);
    end
    return target;
  endfunction

endpackage

// File: rtl/trap_prio_enc.sv
// Fixed-priority selection of one trap source; purely combinational.
module trap_prio_enc
  import trap_ctrl_pkg::*;
(
  input  logic               exc_valid_i,
  input  logic [EXC_W-1:0]   exc_code_i,
  input  logic               mret_i,
  input  logic               ext_int_i,
  input  logic               timer_int_i,
  input  logic               mstatus_mie_i,
  input  logic               meie_i,
  input  logic               mtie_i,
  output logic               valid_c,
  output logic [XLEN-1:0]    code_c,
  output logic [CAUSE_W-1:0] cause_c,
  output logic               is_int_c
);

  logic exc_hit;
  logic ext_ok;
  logic timer_ok;

  // Interrupts only compete when no exception or mret is committing.
  always_comb begin
    exc_hit  = exc_valid_i && (exc_code_i != '0);
    ext_ok   = ext_int_i && meie_i && mstatus_mie_i && !exc_hit && !mret_i;
    timer_ok = timer_int_i && mtie_i && mstatus_mie_i && !exc_hit && !mret_i;
  end

  always_comb begin
    valid_c  = 1'b0;
    code_c   = EXC_NONE;
    cause_c  = '0;
    is_int_c = 1'b0;
    if (exc_hit) begin
      valid_c = 1'b1;
      if (exc_code_i[EXC_BIT_INST_INVALID]) begin
        code_c = EXC_INST_INVALID;
      end else if (exc_code_i[EXC_BIT_ECALL]) begin
        code_c = EXC_ECALL;
      end else if (exc_code_i[EXC_BIT_TRAP]) begin
        code_c = EXC_TRAP;
      end else if (exc_code_i[EXC_BIT_LOAD_MISALIGN]) begin
        code_c = EXC_LOAD_MISALIGN;
      end else if (exc_code_i[EXC_BIT_STORE_MISALIGN]) begin
        code_c = EXC_STORE_MISALIGN;
      end else if (exc_code_i[EXC_BIT_OVERFLOW]) begin
        code_c = EXC_OVERFLOW;
      end
      cause_c = CAUSE_W'(code_c);
    end else if (mret_i) begin
      valid_c = 1'b1;
      code_c  = EXC_MRET;
    end else if (ext_ok) begin
      valid_c  = 1'b1;
      code_c   = EXC_INT_EXT;
      cause_c  = CAUSE_EXT;
      is_int_c = 1'b1;
    end else if (timer_ok) begin
      valid_c  = 1'b1;
      code_c   = EXC_INT_TIMER;
      cause_c  = CAUSE_TIMER;
      is_int_c = 1'b1;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: accepts one prioritised event, presents it to the CSR file
// for one cycle, then flushes the pipeline with the redirect PC.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exc_valid_i,
  input  logic [EXC_W-1:0] exc_code_i,
  input  logic             mret_i,
  input  logic             ext_int_i,
  input  logic             timer_int_i,
  input  logic [XLEN-1:0]  inst_addr_i,
  input  logic             stall_i,
  input  logic [XLEN-1:0]  mstatus_i,
  input  logic [XLEN-1:0]  mie_i,
  input  logic [XLEN-1:0]  mtvec_i,
  input  logic [XLEN-1:0]  mepc_i,
  output logic [XLEN-1:0]  excepttype_o,
  output logic [XLEN-1:0]  current_inst_addr_o,
  output logic             flush_o,
  output logic [XLEN-1:0]  new_pc_o,
  output logic             busy_o
);

  state_e state_q, state_d;

  logic               enc_valid;
  logic [XLEN-1:0]    enc_code;
  logic [CAUSE_W-1:0] enc_cause;
  logic               enc_is_int;
  trap_evt_t          enc_evt;
  logic               accept;

  trap_evt_t       evt_q, evt_d;
  logic [XLEN-1:0] excepttype_q, excepttype_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            flush_q, flush_d;
  logic [XLEN-1:0] new_pc_q, new_pc_d;
  logic            busy_q, busy_d;

  // Only MIE, MTIE and MEIE are consumed from the CSR words.
  logic unused_csr_bits;
  assign unused_csr_bits = ^{mstatus_i[XLEN-1:CSR_MSTATUS_MIE+1],
                             mstatus_i[CSR_MSTATUS_MIE-1:0],
                             mie_i[XLEN-1:CSR_MIE_MEIE+1],
                             mie_i[CSR_MIE_MEIE-1:CSR_MIE_MTIE+1],
                             mie_i[CSR_MIE_MTIE-1:0]};

  trap_prio_enc u_prio (
    .exc_valid_i   (exc_valid_i),
    .exc_code_i    (exc_code_i),
    .mret_i        (mret_i),
    .ext_int_i     (ext_int_i),
    .timer_int_i   (timer_int_i),
    .mstatus_mie_i (mstatus_i[CSR_MSTATUS_MIE]),
    .meie_i        (mie_i[CSR_MIE_MEIE]),
    .mtie_i        (mie_i[CSR_MIE_MTIE]),
    .valid_c       (enc_valid),
    .code_c        (enc_code),
    .cause_c       (enc_cause),
    .is_int_c      (enc_is_int)
  );

  always_comb begin
    enc_evt         = '0;
    enc_evt.code    = enc_code;
    enc_evt.cause   = enc_cause;
    enc_evt.is_int  = enc_is_int;
    enc_evt.is_mret = (enc_code == EXC_MRET);
    accept          = (state_q == ST_IDLE) && enc_valid && !stall_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (accept) state_d = ST_COMMIT;
      ST_COMMIT:   state_d = ST_REDIRECT;
      ST_REDIRECT: if (!stall_i) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; target is captured once and held through stalls.
  always_comb begin
    evt_d        = evt_q;
    excepttype_d = EXC_NONE;
    addr_d       = addr_q;
    flush_d      = 1'b0;
    new_pc_d     = new_pc_q;
    busy_d       = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          evt_d        = enc_evt;
          excepttype_d = enc_evt.code;
          addr_d       = inst_addr_i;
        end
      end
      ST_COMMIT: begin
        flush_d  = 1'b1;
        new_pc_d = trap_target(evt_q, VECTORED_EN, mtvec_i, mepc_i);
      end
      ST_REDIRECT: begin
        flush_d = stall_i;
      end
      default: begin
        flush_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_q        <= '0;
      excepttype_q <= EXC_NONE;
      addr_q       <= '0;
      flush_q      <= 1'b0;
      new_pc_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      evt_q        <= evt_d;
      excepttype_q <= excepttype_d;
      addr_q       <= addr_d;
      flush_q      <= flush_d;
      new_pc_q     <= new_pc_d;
      busy_q       <= busy_d;
    end
  end

  assign excepttype_o        = excepttype_q;
  assign current_inst_addr_o = addr_q;
  assign flush_o             = flush_q;
  assign new_pc_o            = new_pc_q;
  assign busy_o              = busy_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a transaction-level model.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid_i;
  logic [5:0]  exc_code_i;
  logic        mret_i;
  logic        ext_int_i;
  logic        timer_int_i;
  logic [31:0] inst_addr_i;
  logic        stall_i;
  logic [31:0] mstatus_i;
  logic [31:0] mie_i;
  logic [31:0] mtvec_i;
  logic [31:0] mepc_i;
  logic [31:0] excepttype_o;
  logic [31:0] current_inst_addr_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        busy_o;

  always #5 clk = ~clk;

  trap_ctrl #(.VECTORED_EN(1'b1)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .exc_valid_i         (exc_valid_i),
    .exc_code_i          (exc_code_i),
    .mret_i              (mret_i),
    .ext_int_i           (ext_int_i),
    .timer_int_i         (timer_int_i),
    .inst_addr_i         (inst_addr_i),
    .stall_i             (stall_i),
    .mstatus_i           (mstatus_i),
    .mie_i               (mie_i),
    .mtvec_i             (mtvec_i),
    .mepc_i              (mepc_i),
    .excepttype_o        (excepttype_o),
    .current_inst_addr_o (current_inst_addr_o),
    .flush_o             (flush_o),
    .new_pc_o            (new_pc_o),
    .busy_o              (busy_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // excepttype for exc_code bits 0..5 (inst_invalid, ecall, trap, load, store, overflow)
  int exc_tbl [6] = '{5, 1, 2, 6, 7, 4};

  typedef struct packed {
    logic        hit;
    logic        is_int;
    logic [4:0]  cause;
    logic [31:0] code;
  } ref_t;

  function automatic ref_t ref_pick(input logic ev, input logic [5:0] ec, input logic mr,
                                    input logic ei, input logic ti,
                                    input logic [31:0] mst, input logic [31:0] mie);
    ref_t r;
    r = '0;
    if (ev && ec != 6'd0) begin
      // lowest set bit is the highest-priority exception
      for (int i = 5; i >= 0; i--) begin
        if (ec[i]) r.code = 32'(exc_tbl[i]);
      end
      r.hit = 1'b1;
    end else if (mr) begin
      r.hit = 1'b1; r.code = 32'hFFFF_FFFF;
    end else if (mst[3] && mie[11] && ei) begin
      r.hit = 1'b1; r.code = 32'd0; r.cause = 5'd11; r.is_int = 1'b1;
    end else if (mst[3] && mie[7] && ti) begin
      r.hit = 1'b1; r.code = 32'd3; r.cause = 5'd7; r.is_int = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_target(input logic mret, input logic is_int, input logic [4:0] cause,
                                             input logic [31:0] mtvec, input logic [31:0] mepc);
    logic [31:0] base;
    base = mtvec & 32'hFFFF_FFFC;
    if (mret) return mepc;
    if (is_int && mtvec[1:0] == 2'b01) return base + 32'(cause) * 32'd4;
    return base;
  endfunction

  ref_t r_now;
  always_comb r_now = ref_pick(exc_valid_i, exc_code_i, mret_i, ext_int_i, timer_int_i, mstatus_i, mie_i);

  // phase: 0 idle, 1 code presented, 2 redirecting
  int          ph = 0;
  logic        m_valid = 1'b0;
  logic [31:0] m_exc, m_addr, m_pc;
  logic        m_flush;
  ref_t        m_evt;

  always @(posedge clk) begin
    if (rst) begin
      ph      <= 0;
      m_valid <= 1'b1;
      m_exc   <= 32'hFF;
      m_addr  <= 32'd0;
      m_flush <= 1'b0;
      m_pc    <= 32'd0;
    end else if (ph == 0) begin
      if (!stall_i && r_now.hit) begin
        ph     <= 1;
        m_evt  <= r_now;
        m_exc  <= r_now.code;
        m_addr <= inst_addr_i;
      end
    end else if (ph == 1) begin
      ph      <= 2;
      m_exc   <= 32'hFF;
      m_flush <= 1'b1;
      m_pc    <= ref_target(m_evt.code == 32'hFFFF_FFFF, m_evt.is_int, m_evt.cause, mtvec_i, mepc_i);
    end else if (!stall_i) begin
      ph      <= 0;
      m_flush <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("m_excepttype", excepttype_o, m_exc);
      check("m_inst_addr", current_inst_addr_o, m_addr);
      check("m_flush", 32'(flush_o), 32'(m_flush));
      check("m_busy", 32'(busy_o), 32'(ph != 0));
      if (m_flush) check("m_new_pc", new_pc_o, m_pc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    exc_valid_i = 1'b0;
    exc_code_i  = 6'd0;
    mret_i      = 1'b0;
    ext_int_i   = 1'b0;
    timer_int_i = 1'b0;
    stall_i     = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_events();
    inst_addr_i = 32'd0;
    mstatus_i   = 32'd0;
    mie_i       = 32'd0;
    mtvec_i     = 32'h2000;
    mepc_i      = 32'd0;
    step(); step();
    check("rst_excepttype", excepttype_o, 32'hFF);
    check("rst_inst_addr", current_inst_addr_o, 32'd0);
    check("rst_flush", 32'(flush_o), 32'd0);
    check("rst_new_pc", new_pc_o, 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    rst = 1'b0;
    step();

    // load_misalign, direct mtvec
    exc_valid_i = 1'b1; exc_code_i = 6'b001000; inst_addr_i = 32'h100; mtvec_i = 32'h2000;
    step();
    exc_valid_i = 1'b0;
    check("lm_code", excepttype_o, 32'd6);
    check("lm_addr", current_inst_addr_o, 32'h100);
    check("lm_busy", 32'(busy_o), 32'd1);
    check("lm_no_flush", 32'(flush_o), 32'd0);
    step();
    check("lm_flush", 32'(flush_o), 32'd1);
    check("lm_pc", new_pc_o, 32'h2000);
    check("lm_code_idle", excepttype_o, 32'hFF);
    step();
    check("lm_idle_busy", 32'(busy_o), 32'd0);
    check("lm_idle_flush", 32'(flush_o), 32'd0);

    // timer interrupt, vectored
    mstatus_i = 32'h8; mie_i = 32'h80; mtvec_i = 32'h2001; timer_int_i = 1'b1;
    step();
    timer_int_i = 1'b0;
    check("tm_code", excepttype_o, 32'd3);
    step();
    check("tm_pc", new_pc_o, 32'h201C);
    step();
    // MIE cleared: timer ignored
    mstatus_i = 32'h0; timer_int_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("tm_masked_busy", 32'(busy_o), 32'd0);
    end
    timer_int_i = 1'b0;

    // ecall beats external interrupt; interrupt waits for mret to restore MIE
    mstatus_i = 32'h8; mie_i = 32'h880; mtvec_i = 32'h2000;
    exc_valid_i = 1'b1; exc_code_i = 6'b000010; ext_int_i = 1'b1; inst_addr_i = 32'h240;
    step();
    exc_valid_i = 1'b0;
    check("ec_code", excepttype_o, 32'd1);
    mstatus_i = 32'h0;
    step(); step();
    step(); step();
    check("ec_int_held_off", 32'(busy_o), 32'd0);
    mret_i = 1'b1; mepc_i = 32'h244;
    step();
    mret_i = 1'b0;
    check("ec_mret_code", excepttype_o, 32'hFFFF_FFFF);
    mstatus_i = 32'h8;
    step();
    check("ec_mret_pc", new_pc_o, 32'h244);
    step(); step();
    check("ec_ext_code", excepttype_o, 32'd0);
    ext_int_i = 1'b0;
    step(); step();

    // mret
    mepc_i = 32'h4A0; mret_i = 1'b1;
    step();
    mret_i = 1'b0;
    check("mr_code", excepttype_o, 32'hFFFF_FFFF);
    step();
    check("mr_pc", new_pc_o, 32'h4A0);
    step();

    // stall in IDLE holds off acceptance
    stall_i = 1'b1; exc_valid_i = 1'b1; exc_code_i = 6'b000001; inst_addr_i = 32'h300;
    for (int k = 0; k < 3; k++) begin
      step();
      check("st_idle_busy", 32'(busy_o), 32'd0);
    end
    stall_i = 1'b0;
    step();
    exc_valid_i = 1'b0;
    check("st_idle_code", excepttype_o, 32'd5);
    check("st_idle_addr", current_inst_addr_o, 32'h300);
    step(); step();

    // stall in REDIRECT for 3 cycles holds flush for 4
    mtvec_i = 32'h3000; exc_valid_i = 1'b1; exc_code_i = 6'b000100; inst_addr_i = 32'h400;
    step();
    exc_valid_i = 1'b0;
    check("st_rd_code", excepttype_o, 32'd2);
    stall_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("st_rd_flush", 32'(flush_o), 32'd1);
      check("st_rd_pc", new_pc_o, 32'h3000);
      if (k == 3) stall_i = 1'b0;
    end
    step();
    check("st_rd_done", 32'(flush_o), 32'd0);
    check("st_rd_busy", 32'(busy_o), 32'd0);

    // vectored external interrupt, target wraps
    mstatus_i = 32'h8; mie_i = 32'h800; mtvec_i = 32'hFFFF_FFE1; ext_int_i = 1'b1;
    step();
    ext_int_i = 1'b0;
    check("wr_code", excepttype_o, 32'd0);
    step();
    check("wr_pc", new_pc_o, 32'h0000_000C);
    step();

    // exc_valid with empty vector is no event; multi-bit vector picks load_misalign
    exc_valid_i = 1'b1; exc_code_i = 6'd0;
    step();
    check("empty_busy", 32'(busy_o), 32'd0);
    exc_code_i = 6'b111000; inst_addr_i = 32'h480;
    step();
    exc_valid_i = 1'b0;
    check("multi_code", excepttype_o, 32'd6);
    step(); step();

    // reset during REDIRECT
    exc_valid_i = 1'b1; exc_code_i = 6'b010000; inst_addr_i = 32'h500;
    step();
    exc_valid_i = 1'b0;
    check("rr_code", excepttype_o, 32'd7);
    step();
    check("rr_flush", 32'(flush_o), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rr_flush_off", 32'(flush_o), 32'd0);
    check("rr_code_none", excepttype_o, 32'hFF);
    check("rr_busy", 32'(busy_o), 32'd0);
    check("rr_addr", current_inst_addr_o, 32'd0);

    // randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 199) == 0);
      exc_valid_i = ($urandom_range(0, 4) == 0);
      exc_code_i  = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom);
      mret_i      = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) ext_int_i = ~ext_int_i;
      if ($urandom_range(0, 7) == 0) timer_int_i = ~timer_int_i;
      stall_i     = ($urandom_range(0, 3) == 0);
      mstatus_i   = $urandom;
      mie_i       = $urandom;
      mtvec_i     = $urandom;
      if ($urandom_range(0, 1) == 0) mtvec_i[1:0] = 2'b01;
      mepc_i      = $urandom;
      inst_addr_i = $urandom;
      step();
    end

    rst = 1'b0;
    clear_events();
    step(); step(); step(); step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
